// File: rtl/i2c_slave_byte_ctrl.sv
// I2C slave byte-level controller: synchronizes SCL/SDA, detects START/STOP, matches address,
// receives write bytes and serializes read bytes. Optional macro: I2C_SLAVE_GLITCH_FILT_EN.
module i2c_slave_byte_ctrl (
    input  logic       pclk,
    input  logic       preset,
    input  logic       scl_i,
    input  logic       sda_i,
    input  logic [6:0] slv_addr,
    input  logic       tx_eq8,
    output logic       counter_en,
    output logic       counter_clr,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       rw,
    output logic       busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 7;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_WR_DATA  = 3'd3;
    localparam logic [2:0] S_WR_ACK   = 3'd4;
    localparam logic [2:0] S_RD_DATA  = 3'd5;
    localparam logic [2:0] S_RD_ACK   = 3'd6;

    logic              r_scl_s1;
    logic              r_scl_s2;
    logic              r_sda_s1;
    logic              r_sda_s2;
    logic              r_scl_d;
    logic              r_sda_d;
    logic              w_scl;
    logic              w_sda;
    logic              w_scl_rise;
    logic              w_scl_fall;
    logic              w_start;
    logic              w_stop;

    logic [2:0]        r_state;
    logic [BYTE_W-1:0] r_rx_sr;
    logic [BYTE_W-2:0] r_tx_sr;
    logic              r_ack;
    logic              r_rw;
    logic [BYTE_W-1:0] r_rx_data;
    logic              r_sda_oe;
    logic              r_cnt_en;
    logic              r_cnt_clr;
    logic              r_rx_valid;
    logic              r_tx_load;
    logic              r_busy;

    logic [2:0]        w_nxt_state;
    logic [BYTE_W-1:0] w_nxt_rx_sr;
    logic [BYTE_W-2:0] w_nxt_tx_sr;
    logic              w_nxt_ack;
    logic              w_nxt_rw;
    logic [BYTE_W-1:0] w_nxt_rx_data;
    logic              w_nxt_sda_oe;
    logic              w_nxt_cnt_en;
    logic              w_nxt_cnt_clr;
    logic              w_nxt_rx_valid;
    logic              w_nxt_tx_load;

    // Two-flop synchronizers plus previous-value flops for edge detection (idle bus = 1)
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_scl_d  <= w_scl;
            r_sda_d  <= w_sda;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILT_EN
    logic [2:0] r_scl_h;
    logic [2:0] r_sda_h;
    logic       r_scl_f;
    logic       r_sda_f;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

    // 3-sample majority vote removes single-pclk spikes on the synced lines
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_scl_h <= 3'b111;
            r_sda_h <= 3'b111;
            r_scl_f <= 1'b1;
            r_sda_f <= 1'b1;
        end else begin
            r_scl_h <= {r_scl_h[1:0], r_scl_s2};
            r_sda_h <= {r_sda_h[1:0], r_sda_s2};
            r_scl_f <= maj3(r_scl_h);
            r_sda_f <= maj3(r_sda_h);
        end
    end

    assign w_scl = r_scl_f;
    assign w_sda = r_sda_f;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
    assign w_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;

    // Next-state and next-output logic; START/STOP override every state
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_rx_sr    = r_rx_sr;
        w_nxt_tx_sr    = r_tx_sr;
        w_nxt_ack      = r_ack;
        w_nxt_rw       = r_rw;
        w_nxt_rx_data  = r_rx_data;
        w_nxt_sda_oe   = r_sda_oe;
        w_nxt_cnt_en   = 1'b0;
        w_nxt_cnt_clr  = 1'b0;
        w_nxt_rx_valid = 1'b0;
        w_nxt_tx_load  = 1'b0;

        if (w_stop) begin
            w_nxt_state   = S_IDLE;
            w_nxt_cnt_clr = 1'b1;
            w_nxt_sda_oe  = 1'b0;
        end else if (w_start) begin
            w_nxt_state   = S_ADDR;
            w_nxt_cnt_clr = 1'b1;
            w_nxt_sda_oe  = 1'b0;
            w_nxt_rx_sr   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_nxt_sda_oe = 1'b0;
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_nxt_rx_sr  = {r_rx_sr[BYTE_W-2:0], w_sda};
                        w_nxt_cnt_en = 1'b1;
                    end else if (w_scl_fall && tx_eq8) begin
                        if (r_rx_sr[BYTE_W-1:1] == slv_addr) begin
                            w_nxt_state  = S_ADDR_ACK;
                            w_nxt_rw     = r_rx_sr[0];
                            w_nxt_sda_oe = 1'b1;
                        end else begin
                            w_nxt_state  = S_IDLE;
                            w_nxt_sda_oe = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_nxt_cnt_clr = 1'b1;
                        if (r_rw) begin
                            w_nxt_tx_sr   = tx_data[BYTE_W-2:0];
                            w_nxt_tx_load = 1'b1;
                            w_nxt_sda_oe  = ~tx_data[BYTE_W-1];
                            w_nxt_state   = S_RD_DATA;
                        end else begin
                            w_nxt_sda_oe  = 1'b0;
                            w_nxt_state   = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_nxt_rx_sr  = {r_rx_sr[BYTE_W-2:0], w_sda};
                        w_nxt_cnt_en = 1'b1;
                    end else if (w_scl_fall && tx_eq8) begin
                        w_nxt_rx_data  = r_rx_sr;
                        w_nxt_rx_valid = 1'b1;
                        w_nxt_sda_oe   = 1'b1;
                        w_nxt_state    = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_nxt_sda_oe  = 1'b0;
                        w_nxt_cnt_clr = 1'b1;
                        w_nxt_state   = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_rise) begin
                        w_nxt_cnt_en = 1'b1;
                    end else if (w_scl_fall) begin
                        if (tx_eq8) begin
                            w_nxt_sda_oe = 1'b0;
                            w_nxt_state  = S_RD_ACK;
                        end else begin
                            w_nxt_tx_sr  = {r_tx_sr[BYTE_W-3:0], 1'b0};
                            w_nxt_sda_oe = ~r_tx_sr[BYTE_W-2];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        w_nxt_ack = w_sda;
                    end else if (w_scl_fall) begin
                        w_nxt_cnt_clr = 1'b1;
                        if (!r_ack) begin
                            w_nxt_tx_sr   = tx_data[BYTE_W-2:0];
                            w_nxt_tx_load = 1'b1;
                            w_nxt_sda_oe  = ~tx_data[BYTE_W-1];
                            w_nxt_state   = S_RD_DATA;
                        end else begin
                            w_nxt_sda_oe  = 1'b0;
                            w_nxt_state   = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_nxt_state  = S_IDLE;
                    w_nxt_sda_oe = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= S_IDLE;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            r_ack      <= 1'b0;
            r_rw       <= 1'b0;
            r_rx_data  <= '0;
            r_sda_oe   <= 1'b0;
            r_cnt_en   <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_rx_sr    <= w_nxt_rx_sr;
            r_tx_sr    <= w_nxt_tx_sr;
            r_ack      <= w_nxt_ack;
            r_rw       <= w_nxt_rw;
            r_rx_data  <= w_nxt_rx_data;
            r_sda_oe   <= w_nxt_sda_oe;
            r_cnt_en   <= w_nxt_cnt_en;
            r_cnt_clr  <= w_nxt_cnt_clr;
            r_rx_valid <= w_nxt_rx_valid;
            r_tx_load  <= w_nxt_tx_load;
            r_busy     <= (w_nxt_state != S_IDLE);
        end
    end

    assign counter_en  = r_cnt_en;
    assign counter_clr = r_cnt_clr;
    assign sda_oe      = r_sda_oe;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_load     = r_tx_load;
    assign rw          = r_rw;
    assign busy        = r_busy;

    localparam int unsigned ADDR_CHK = ADDR_W;
    if (ADDR_CHK != BYTE_W - 1) begin : g_width_guard
        $error("address width must be one less than byte width");
    end

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench for i2c_slave_byte_ctrl: bus-master tasks, external bit-counter model,
// event counters and hand-computed expectations.
module tb_i2c_slave_byte_ctrl;

    logic       pclk = 1'b0;
    logic       preset;
    logic       scl_m;
    logic       sda_m;
    logic [6:0] slv_addr;
    logic [7:0] tx_data;
    logic       tx_eq8;
    logic       counter_en;
    logic       counter_clr;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       rw;
    logic       busy;
    logic       sda_line;
    logic [3:0] bit_cnt;
    logic       glitch_on;

    int n_chk;
    int n_fail;
    int rxv_cnt;
    int ld_cnt;
    int clr_cnt;
    int oe_cnt;
    int en_cnt;
    int both_cnt;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_byte_ctrl dut (
        .pclk        (pclk),
        .preset      (preset),
        .scl_i       (scl_m),
        .sda_i       (sda_line),
        .slv_addr    (slv_addr),
        .tx_eq8      (tx_eq8),
        .counter_en  (counter_en),
        .counter_clr (counter_clr),
        .sda_oe      (sda_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .rw          (rw),
        .busy        (busy)
    );

    always #5 pclk = ~pclk;

    // External bit counter the controller drives
    always @(posedge pclk) begin
        if (preset || counter_clr) bit_cnt <= 4'd0;
        else if (counter_en)       bit_cnt <= bit_cnt + 4'd1;
    end
    assign tx_eq8 = (bit_cnt == 4'd8);

    always @(negedge pclk) begin
        if (!preset) begin
            if (rx_valid)                  rxv_cnt++;
            if (tx_load)                   ld_cnt++;
            if (counter_clr)               clr_cnt++;
            if (sda_oe)                    oe_cnt++;
            if (counter_en)                en_cnt++;
            if (counter_en && counter_clr) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // One SCL period starting and ending with SCL low; s = line value while SCL high
    task automatic i2c_bit(input logic b, output logic s);
        wait_clk(5);
        sda_m = b;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        s = sda_line;
        if (glitch_on) begin
            scl_m = 1'b0;
            wait_clk(1);
            scl_m = 1'b1;
        end
        wait_clk(5);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m = 1'b0;
        wait_clk(10);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(5);
        sda_m = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m = 1'b1;
        wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
        i2c_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            d[i] = s;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rd;
        int         c_rxv, c_ld, c_clr, c_oe, c_en;

        preset    = 1'b1;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        slv_addr  = 7'h48;
        tx_data   = 8'h3C;
        glitch_on = 1'b0;
        wait_clk(3);
        check("rst_busy",     32'(busy),        32'h0);
        check("rst_sda_oe",   32'(sda_oe),      32'h0);
        check("rst_rx_data",  32'(rx_data),     32'h0);
        check("rst_rw",       32'(rw),          32'h0);
        check("rst_rx_valid", 32'(rx_valid),    32'h0);
        check("rst_tx_load",  32'(tx_load),     32'h0);
        check("rst_cnt_en",   32'(counter_en),  32'h0);
        check("rst_cnt_clr",  32'(counter_clr), 32'h0);
        preset = 1'b0;
        wait_clk(5);

        // Write 0x90 then 0xA5
        c_rxv = rxv_cnt;
        i2c_start();
        check("wr_busy_after_start", 32'(busy), 32'h1);
        write_byte(8'h90, ack);
        check("wr_addr_ack", 32'(ack), 32'h0);
        write_byte(8'hA5, ack);
        check("wr_data_ack", 32'(ack), 32'h0);
        check("wr_rw", 32'(rw), 32'h0);
        i2c_stop();
        check("wr_rx_data", 32'(rx_data), 32'hA5);
        check("wr_rx_valid_cnt", 32'(rxv_cnt - c_rxv), 32'd1);
        check("wr_busy_after_stop", 32'(busy), 32'h0);

        // Address mismatch 0x92
        c_rxv = rxv_cnt;
        c_oe  = oe_cnt;
        i2c_start();
        write_byte(8'h92, ack);
        check("nm_ack", 32'(ack), 32'h1);
        wait_clk(6);
        check("nm_busy", 32'(busy), 32'h0);
        check("nm_oe_cycles", 32'(oe_cnt - c_oe), 32'd0);
        i2c_stop();
        check("nm_rx_valid_cnt", 32'(rxv_cnt - c_rxv), 32'd0);

        // Read 0x91: 0x3C (ACK) then 0xC3 (NACK)
        c_ld = ld_cnt;
        tx_data = 8'h3C;
        i2c_start();
        write_byte(8'h91, ack);
        check("rd_addr_ack", 32'(ack), 32'h0);
        check("rd_rw", 32'(rw), 32'h1);
        read_byte(rd);
        check("rd_byte0", 32'(rd), 32'h3C);
        tx_data = 8'hC3;
        i2c_bit(1'b0, s);
        read_byte(rd);
        check("rd_byte1", 32'(rd), 32'hC3);
        i2c_bit(1'b1, s);
        wait_clk(6);
        check("rd_busy_after_nack", 32'(busy), 32'h0);
        check("rd_tx_load_cnt", 32'(ld_cnt - c_ld), 32'd2);
        i2c_stop();

        // Repeated START after 4 data bits, then read 0x5A
        c_rxv = rxv_cnt;
        i2c_start();
        write_byte(8'h90, ack);
        check("rs_addr_ack", 32'(ack), 32'h0);
        i2c_bit(1'b1, s);
        i2c_bit(1'b0, s);
        i2c_bit(1'b1, s);
        i2c_bit(1'b0, s);
        c_clr = clr_cnt;
        i2c_start();
        check("rs_clr_on_start", 32'(clr_cnt - c_clr), 32'd1);
        check("rs_cnt_cleared", 32'(bit_cnt), 32'd0);
        tx_data = 8'h5A;
        write_byte(8'h91, ack);
        check("rs_addr2_ack", 32'(ack), 32'h0);
        read_byte(rd);
        check("rs_read", 32'(rd), 32'h5A);
        i2c_bit(1'b1, s);
        i2c_stop();
        check("rs_no_rx_valid", 32'(rxv_cnt - c_rxv), 32'd0);
        check("rs_rx_data_kept", 32'(rx_data), 32'hA5);

`ifdef I2C_SLAVE_GLITCH_FILT_EN
        // Low spike on SCL inside every high phase must not add counts or shifts
        i2c_start();
        write_byte(8'h90, ack);
        check("gl_addr_ack", 32'(ack), 32'h0);
        c_en = en_cnt;
        glitch_on = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            rd = 8'h69;
            i2c_bit(rd[i], s);
        end
        glitch_on = 1'b0;
        i2c_bit(1'b1, ack);
        check("gl_en_cnt", 32'(en_cnt - c_en), 32'd8);
        check("gl_data_ack", 32'(ack), 32'h0);
        check("gl_rx_data", 32'(rx_data), 32'h69);
        i2c_stop();
`endif

        // Reset while acknowledging a written byte
        i2c_start();
        write_byte(8'h90, ack);
        check("rr_addr_ack", 32'(ack), 32'h0);
        for (int i = 7; i >= 0; i--) begin
            rd = 8'h5C;
            i2c_bit(rd[i], s);
        end
        sda_m = 1'b1;
        wait_clk(8);
        check("rr_oe_before", 32'(sda_oe), 32'h1);
        check("rr_rx_before", 32'(rx_data), 32'h5C);
        preset = 1'b1;
        wait_clk(1);
        check("rr_sda_oe", 32'(sda_oe),   32'h0);
        check("rr_busy",   32'(busy),     32'h0);
        check("rr_rx_data",32'(rx_data),  32'h0);
        check("rr_rw",     32'(rw),       32'h0);
        check("rr_flags",  32'({counter_en, counter_clr, rx_valid, tx_load}), 32'h0);
        preset = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);

        // Traffic without a START is ignored
        c_oe = oe_cnt;
        c_en = en_cnt;
        scl_m = 1'b0;
        write_byte(8'h90, ack);
        check("ns_ack", 32'(ack), 32'h1);
        check("ns_busy", 32'(busy), 32'h0);
        check("ns_en_cnt", 32'(en_cnt - c_en), 32'd0);
        check("ns_oe_cycles", 32'(oe_cnt - c_oe), 32'd0);
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);

        check("en_clr_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
